// File: rtl/sd_feeder_pkg.sv
// Shared types and constants for the SD sector feeder.
// Build option: define SECTOR_HDR_EN to prefix every sector with its 4-byte address.
package sd_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int SEC_BYTES = 512;

`ifdef SECTOR_HDR_EN
  localparam int HDR_BYTES = 4;
`else
  localparam int HDR_BYTES = 0;
`endif

  // Big-endian header byte idx of a sector address.
  function automatic logic [7:0] sec_hdr_byte(input logic [31:0] s, input logic [1:0] idx);
    case (idx)
      2'd0:    sec_hdr_byte = s[31:24];
      2'd1:    sec_hdr_byte = s[23:16];
      2'd2:    sec_hdr_byte = s[15:8];
      default: sec_hdr_byte = s[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sd_pingpong_ram.sv
// Two 512-byte banks as one simple dual-port RAM; address bit 9 selects the bank.
// Read data is registered so the array maps onto a block RAM.
module sd_pingpong_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [9:0] waddr,
  input  logic [7:0] wdata,
  input  logic [9:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:1023];
  logic [7:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sd_sector_feeder.sv
// Packs the DDR3 byte stream into ping-pong 512-byte sectors and serves them to the SD writer.
// Build option: SECTOR_HDR_EN puts the sector address in bytes 0..3 of each sector.
module sd_sector_feeder
  import sd_feeder_pkg::*;
#(
  parameter logic [31:0] START_SEC = 32'd8192,
  parameter logic [31:0] END_SEC   = 32'd7_000_000,
  parameter int          SEC_BYTES = 512
) (
  input  logic        SD_clk,
  input  logic        rst,
  input  logic        init,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        write_req,
  output logic [31:0] sec,
  input  logic        write_o,
  input  logic        next_byte_req,
  output logic [7:0]  data_transfer,
  output logic        done,
  output logic        overrun
);

  localparam logic [8:0] LAST_IDX = 9'(SEC_BYTES - 1);
  localparam logic [9:0] OVR_IDX  = 10'(SEC_BYTES);
  localparam logic [8:0] WR_START = 9'(HDR_BYTES);

  state_e      state_q, state_d;
  logic        fill_bank_q, fill_bank_d;
  logic        drain_bank_q, drain_bank_d;
  logic [1:0]  full_q, full_d;
  logic [8:0]  wr_ptr_q, wr_ptr_d;
  logic [9:0]  rd_idx_q, rd_idx_d;
  logic [31:0] sec_q, sec_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        write_req_q, write_req_d;
  logic        din_ready_q, din_ready_d;
  logic        wo_q, wo_d;

  logic        ram_we;
  logic [9:0]  ram_waddr;
  logic [9:0]  ram_raddr;
  logic [7:0]  ram_rdata;
  logic [7:0]  byte_s;
  logic        wo_rise;

  sd_pingpong_ram u_ram (
    .clk   (SD_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (din),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Fill side, drain FSM and all next-state values.
  always_comb begin
    state_d      = state_q;
    fill_bank_d  = fill_bank_q;
    drain_bank_d = drain_bank_q;
    full_d       = full_q;
    wr_ptr_d     = wr_ptr_q;
    rd_idx_d     = rd_idx_q;
    sec_d        = sec_q;
    data_d       = data_q;
    done_d       = done_q;
    overrun_d    = overrun_q;
    write_req_d  = 1'b0;
    wo_d         = write_o;
    wo_rise      = write_o & ~wo_q;
    ram_we       = din_valid & din_ready_q;
    ram_waddr    = {fill_bank_q, wr_ptr_q};

`ifdef SECTOR_HDR_EN
    if (rd_idx_q < 10'(HDR_BYTES)) begin
      byte_s = sec_hdr_byte(sec_q, rd_idx_q[1:0]);
    end else begin
      byte_s = ram_rdata;
    end
`else
    byte_s = ram_rdata;
`endif

    if (ram_we) begin
      if (wr_ptr_q == LAST_IDX) begin
        full_d[fill_bank_q] = 1'b1;
        wr_ptr_d            = WR_START;
        fill_bank_d         = ~fill_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 9'd1;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (init && full_q[drain_bank_q] && !done_q) begin
          state_d     = S_REQ;
          write_req_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        rd_idx_d = 10'd0;
        if (!init) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // Losing init keeps the bank full so the same sector is re-sent.
        if (!init) begin
          state_d = S_IDLE;
        end else begin
          if (next_byte_req) begin
            if (rd_idx_q == OVR_IDX) begin
              data_d    = 8'h00;
              overrun_d = 1'b1;
            end else begin
              data_d   = byte_s;
              rd_idx_d = rd_idx_q + 10'd1;
            end
          end else begin
            data_d = data_q;
          end
          if (wo_rise) begin
            state_d = S_DONE;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_DONE: begin
        full_d[drain_bank_q] = 1'b0;
        drain_bank_d         = ~drain_bank_q;
        if (sec_q == END_SEC) begin
          done_d = 1'b1;
        end else begin
          sec_d = sec_q + 32'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read one byte ahead so a pulse can be answered on the very next edge.
    ram_raddr   = {drain_bank_q, rd_idx_d[8:0]};
    din_ready_d = ~done_d & ~full_d[fill_bank_d];
  end

  // State and output registers.
  always_ff @(posedge SD_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      full_q       <= 2'b00;
      wr_ptr_q     <= WR_START;
      rd_idx_q     <= 10'd0;
      sec_q        <= START_SEC;
      data_q       <= 8'h00;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      write_req_q  <= 1'b0;
      din_ready_q  <= 1'b0;
      wo_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_bank_q  <= fill_bank_d;
      drain_bank_q <= drain_bank_d;
      full_q       <= full_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_idx_q     <= rd_idx_d;
      sec_q        <= sec_d;
      data_q       <= data_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      write_req_q  <= write_req_d;
      din_ready_q  <= din_ready_d;
      wo_q         <= wo_d;
    end
  end

  assign din_ready     = din_ready_q;
  assign write_req     = write_req_q;
  assign sec           = sec_q;
  assign data_transfer = data_q;
  assign done          = done_q;
  assign overrun       = overrun_q;

endmodule
